// File: rtl/idex_stage_buffer.sv
// ---------------------------------------------------------------------------
// idex_stage_buffer
//   ID -> EX pipeline register with a one-entry skid buffer. The handshake
//   outputs (in_ready, out_valid) come from state only, so there is no
//   combinational path from input to output. A flush squashes all held
//   payloads. A saturating counter records EX-idle cycles.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid / in_ready          upstream (ID) handshake
//   in_pc, in_inst, in_rs, in_rt payload from ID
//   in_ctrl_*                    control bits / ALU opcode from ID
//   out_valid / out_ready        downstream (EX) handshake
//   out_*                        registered payload presented to EX
//   flush                        synchronous squash of held payloads
//   bubble_clr                   synchronous clear of bubble_cnt
//   bubble_cnt                   saturating count of EX-idle cycles
//
// state | meaning
// EMPTY | nothing held; upstream may push
// ONE   | main holds the payload shown to EX; upstream may push
// TWO   | main shown to EX, skid holds the next payload; upstream stalled
// ---------------------------------------------------------------------------
module idex_stage_buffer #(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INST_W-1:0]  in_inst,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  input  logic               in_ctrl_mread,
  input  logic               in_ctrl_mwrite,
  input  logic               in_ctrl_regwrite,
  input  logic [ALUOP_W-1:0] in_ctrl_aluop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INST_W-1:0]  out_inst,
  output logic [DATA_W-1:0]  out_rs,
  output logic [DATA_W-1:0]  out_rt,
  output logic               out_ctrl_mread,
  output logic               out_ctrl_mwrite,
  output logic               out_ctrl_regwrite,
  output logic [ALUOP_W-1:0] out_ctrl_aluop,
  input  logic               flush,
  input  logic               bubble_clr,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]    main_pc_q, skid_pc_q;
  logic [INST_W-1:0]  main_inst_q, skid_inst_q;
  logic [DATA_W-1:0]  main_rs_q, skid_rs_q;
  logic [DATA_W-1:0]  main_rt_q, skid_rt_q;
  logic               main_mread_q, skid_mread_q;
  logic               main_mwrite_q, skid_mwrite_q;
  logic               main_regwrite_q, skid_regwrite_q;
  logic [ALUOP_W-1:0] main_aluop_q, skid_aluop_q;

  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  logic accept, consume;
  logic load_main_in, load_main_skid, load_skid_in;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      // Accepted data is dropped; a same-cycle consume needs no action.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = TWO;
            load_skid_in = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_clr) begin
      bubble_cnt_d = '0;
    end else if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= EMPTY;
      main_pc_q       <= '0;
      main_inst_q     <= '0;
      main_rs_q       <= '0;
      main_rt_q       <= '0;
      main_mread_q    <= 1'b0;
      main_mwrite_q   <= 1'b0;
      main_regwrite_q <= 1'b0;
      main_aluop_q    <= '0;
      skid_pc_q       <= '0;
      skid_inst_q     <= '0;
      skid_rs_q       <= '0;
      skid_rt_q       <= '0;
      skid_mread_q    <= 1'b0;
      skid_mwrite_q   <= 1'b0;
      skid_regwrite_q <= 1'b0;
      skid_aluop_q    <= '0;
      bubble_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
      if (load_main_in) begin
        main_pc_q       <= in_pc;
        main_inst_q     <= in_inst;
        main_rs_q       <= in_rs;
        main_rt_q       <= in_rt;
        main_mread_q    <= in_ctrl_mread;
        main_mwrite_q   <= in_ctrl_mwrite;
        main_regwrite_q <= in_ctrl_regwrite;
        main_aluop_q    <= in_ctrl_aluop;
      end else if (load_main_skid) begin
        main_pc_q       <= skid_pc_q;
        main_inst_q     <= skid_inst_q;
        main_rs_q       <= skid_rs_q;
        main_rt_q       <= skid_rt_q;
        main_mread_q    <= skid_mread_q;
        main_mwrite_q   <= skid_mwrite_q;
        main_regwrite_q <= skid_regwrite_q;
        main_aluop_q    <= skid_aluop_q;
      end
      if (load_skid_in) begin
        skid_pc_q       <= in_pc;
        skid_inst_q     <= in_inst;
        skid_rs_q       <= in_rs;
        skid_rt_q       <= in_rt;
        skid_mread_q    <= in_ctrl_mread;
        skid_mwrite_q   <= in_ctrl_mwrite;
        skid_regwrite_q <= in_ctrl_regwrite;
        skid_aluop_q    <= in_ctrl_aluop;
      end
    end
  end

  // Data fields keep the last main contents; control is masked so an idle
  // EX stage never sees a stale memory or register-file write.
  assign out_pc            = main_pc_q;
  assign out_inst          = main_inst_q;
  assign out_rs            = main_rs_q;
  assign out_rt            = main_rt_q;
  assign out_ctrl_mread    = main_mread_q & out_valid;
  assign out_ctrl_mwrite   = main_mwrite_q & out_valid;
  assign out_ctrl_regwrite = main_regwrite_q & out_valid;
  assign out_ctrl_aluop    = out_valid ? main_aluop_q : '0;
  assign bubble_cnt        = bubble_cnt_q;

endmodule
